// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the instruction/address path types, the queue entry layout and the issue rule.
package fetch_unit_pkg;

   localparam int INSN_WIDTH      = 32;
   localparam int INSN_ADDR_WIDTH = 32;
   localparam int INSN_MEM_OFFSET = 2;

   typedef logic [INSN_WIDTH-1:0]      InsnPath;
   typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;

   typedef struct packed {
      InsnPath     insn;
      InsnAddrPath pc;
   } FetchEntry;

   localparam int FETCH_QUEUE_DEPTH = 2;
   localparam int FETCH_ENTRY_WIDTH = $bits(FetchEntry);

   localparam InsnAddrPath FETCH_PC_INC_DEFAULT = InsnAddrPath'(32'd1 << INSN_MEM_OFFSET);

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HOLD = 2'd2
   } FetchState;

   // A new request may go out only if queued + in-flight - leaving entries stay <= 1.
   function automatic logic fetch_can_issue(input logic [1:0] count,
                                            input logic       req_valid,
                                            input logic       deq);
      logic [2:0] load;
      logic [2:0] limit;
      load  = {1'b0, count} + {2'b00, req_valid};
      limit = {2'b00, deq} + 3'd1;
      return (load <= limit);
   endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: 2-entry in-order FIFO of packed FetchEntry words.
// Slot 0 is always the head; flush takes priority over enqueue/dequeue.
module fetch_queue
   import fetch_unit_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         enq,
   input  logic [FETCH_ENTRY_WIDTH-1:0] enq_data,
   input  logic                         deq,
   output logic [1:0]                   count,
   output logic [FETCH_ENTRY_WIDTH-1:0] head
);

   logic [FETCH_ENTRY_WIDTH-1:0] slot0_r;
   logic [FETCH_ENTRY_WIDTH-1:0] slot1_r;
   logic [1:0]                   count_r;
   logic                         deq_ok_s;
   logic                         enq_ok_s;

   // Qualify requests so an empty pop or a full push can never corrupt the queue.
   always_comb begin
      deq_ok_s = deq && (count_r != 2'd0);
      enq_ok_s = enq && ((count_r != 2'd2) || deq_ok_s);
   end

   // Storage and occupancy; a dequeue shifts slot 1 into the head position.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= 2'd0;
         slot0_r <= {FETCH_ENTRY_WIDTH{1'b0}};
         slot1_r <= {FETCH_ENTRY_WIDTH{1'b0}};
      end else if (flush) begin
         count_r <= 2'd0;
      end else begin
         case ({enq_ok_s, deq_ok_s})
            2'b10: begin
               if (count_r == 2'd0) slot0_r <= enq_data;
               else                 slot1_r <= enq_data;
               count_r <= count_r + 2'd1;
            end
            2'b01: begin
               slot0_r <= slot1_r;
               count_r <= count_r - 2'd1;
            end
            2'b11: begin
               if (count_r == 2'd1) begin
                  slot0_r <= enq_data;
               end else begin
                  slot0_r <= slot1_r;
                  slot1_r <= enq_data;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   assign count = count_r;
   assign head  = slot0_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem request tracking and a 2-deep output queue to decode.
// Optional macro FETCH_BYPASS_EN forwards imem data straight to decode when the queue is empty.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [INSN_ADDR_WIDTH-1:0] RESET_PC = {INSN_ADDR_WIDTH{1'b0}},
   parameter logic [INSN_ADDR_WIDTH-1:0] PC_INC   = FETCH_PC_INC_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [INSN_ADDR_WIDTH-1:0] imemAddr,
   input  logic [INSN_WIDTH-1:0]      imemInsn,
   output logic                       outValid,
   input  logic                       outReady,
   output logic [INSN_WIDTH-1:0]      outInsn,
   output logic [INSN_ADDR_WIDTH-1:0] outPc,
   input  logic                       redirect,
   input  logic [INSN_ADDR_WIDTH-1:0] redirectPc
);

   FetchState   state_r;
   FetchState   state_nx_s;
   InsnAddrPath fetch_pc_r;
   InsnAddrPath req_pc_r;
   logic        req_valid_r;
   logic        issue_s;
   logic        deq_s;
   logic        bypass_s;
   logic        q_enq_s;
   logic        q_deq_s;
   logic [1:0]  q_count_s;
   FetchEntry   head_s;
   FetchEntry   enq_entry_s;

   assign enq_entry_s = '{insn: imemInsn, pc: req_pc_r};

   fetch_queue u_queue (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .enq      (q_enq_s),
      .enq_data (enq_entry_s),
      .deq      (q_deq_s),
      .count    (q_count_s),
      .head     (head_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= FETCH_BOOT;
      else      state_r <= state_nx_s;
   end

   // Next-state and issue decision; redirect always resumes in RUN.
   always_comb begin
      issue_s    = 1'b0;
      state_nx_s = FETCH_BOOT;
      case (state_r)
         FETCH_BOOT: begin
            issue_s    = 1'b1;
            state_nx_s = FETCH_RUN;
         end
         FETCH_RUN, FETCH_HOLD: begin
            issue_s    = fetch_can_issue(q_count_s, req_valid_r, deq_s);
            state_nx_s = issue_s ? FETCH_RUN : FETCH_HOLD;
         end
         default: begin
            issue_s    = 1'b0;
            state_nx_s = FETCH_BOOT;
         end
      endcase
      if (redirect) state_nx_s = FETCH_RUN;
      else          state_nx_s = state_nx_s;
   end

   // Decode-side outputs, queue controls and the memory address.
   always_comb begin
      bypass_s = 1'b0;
`ifdef FETCH_BYPASS_EN
      bypass_s = (q_count_s == 2'd0) && req_valid_r;
`endif
      if (bypass_s) begin
         outValid = 1'b1;
         outInsn  = imemInsn;
         outPc    = req_pc_r;
      end else begin
         outValid = (q_count_s != 2'd0);
         outInsn  = head_s.insn;
         outPc    = head_s.pc;
      end
      deq_s   = outValid && outReady;
      q_deq_s = deq_s && !bypass_s;
      q_enq_s = req_valid_r && !(bypass_s && outReady);

      if (!rst)          imemAddr = RESET_PC;
      else if (redirect) imemAddr = redirectPc;
      else if (issue_s)  imemAddr = fetch_pc_r;
      else               imemAddr = req_pc_r;
   end

   // PC and in-flight request tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r  <= RESET_PC;
         req_pc_r    <= RESET_PC;
         req_valid_r <= 1'b0;
      end else if (redirect) begin
         fetch_pc_r  <= redirectPc + PC_INC;
         req_pc_r    <= redirectPc;
         req_valid_r <= 1'b1;
      end else if (issue_s) begin
         fetch_pc_r  <= fetch_pc_r + PC_INC;
         req_pc_r    <= fetch_pc_r;
         req_valid_r <= 1'b1;
      end else begin
         req_valid_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, insn}, a negedge monitor checks transfers.
module tb_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } exp_t;

`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] imemAddr;
   logic [31:0] imemInsn;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInsn;
   logic [31:0] outPc;
   logic        redirect;
   logic [31:0] redirectPc;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;
   int   pops_mark;
   int   pops_random;

   fetch_unit #(.RESET_PC(32'h0), .PC_INC(32'd4)) dut (
      .clk        (clk),
      .rst        (rst),
      .imemAddr   (imemAddr),
      .imemInsn   (imemInsn),
      .outValid   (outValid),
      .outReady   (outReady),
      .outInsn    (outInsn),
      .outPc      (outPc),
      .redirect   (redirect),
      .redirectPc (redirectPc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   always @(posedge clk) imemInsn <= mem_word(imemAddr);

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endfunction

   function automatic void push_seq(input logic [31:0] start, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc   = start + 32'(4 * i);
         e.insn = mem_word(e.pc);
         exp_q.push_back(e);
      end
   endfunction

   // Monitor: every accepted transfer must match the head of the expected stream.
   always @(negedge clk) begin
      if (rst && outValid && outReady) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual_pc=0x%08h expected=none", outPc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_pc", outPc, mon_e.pc);
            chk("sb_insn", outInsn, mon_e.insn);
         end
         pops++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int exp_lat, input int base);
      int lat;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (outValid) begin
            lat = i + base;
            break;
         end
      end
      chk(name, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      rst        = 1'b1;
      outReady   = 1'b1;
      redirect   = 1'b0;
      redirectPc = 32'h0;
      #1 rst = 1'b0;
      #2;
      chk("rst_valid", {31'd0, outValid}, 32'd0);
      chk("rst_addr", imemAddr, 32'h0);
      push_seq(32'h0, 64);
      step();
      #1 rst = 1'b1;

      // Boot: latency from the BOOT cycle, then back-to-back delivery.
      wait_valid("boot_lat", LAT, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("boot_stream", {31'd0, outValid}, 32'd1);
      end

      // Backpressure: queue fills, address frozen on the last issued PC.
      step();
      outReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            chk("hold_valid", {31'd0, outValid}, 32'd1);
            chk("hold_addr", imemAddr, exp_q[0].pc + 32'd4);
         end
      end
      step();
      outReady = 1'b1;
      #1 chk("resume_addr", imemAddr, exp_q[0].pc + 32'd8);
      repeat (8) step();

      // Redirect while full, with a handshake in the same cycle.
      outReady = 1'b0;
      repeat (4) step();
      redirect   = 1'b1;
      redirectPc = 32'h40;
      outReady   = 1'b1;
      pops_mark  = pops;
      #1;
      chk("redir_addr", imemAddr, 32'h40);
      chk("redir_valid", {31'd0, outValid}, 32'd1);
      #5;
      chk("redir_hs", 32'(pops - pops_mark), 32'd1);
      exp_q.delete();
      push_seq(32'h40, 64);
      step();
      redirect = 1'b0;
      wait_valid("redir_lat", LAT, 1);
      repeat (6) step();

      // Address wrap at the top of the 32-bit space.
      redirect   = 1'b1;
      redirectPc = 32'hFFFF_FFF8;
      #5;
      exp_q.delete();
      push_seq(32'hFFFF_FFF8, 64);
      step();
      redirect = 1'b0;
      repeat (8) step();

      // Asynchronous reset with two entries queued.
      outReady = 1'b0;
      repeat (4) step();
      #2 rst = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, outValid}, 32'd0);
      chk("midrst_addr", imemAddr, 32'h0);
      exp_q.delete();
      push_seq(32'h0, 1200);
      step();
      #1 rst = 1'b1;
      outReady = 1'b1;
      wait_valid("midrst_lat", LAT, 0);

      // Random backpressure; the stream must stay gap-free and the queue bounded.
      pops_mark = pops;
      for (int i = 0; i < 1000; i++) begin
         step();
         outReady = 1'($urandom_range(0, 1));
         chk("count_bound", {31'd0, (dut.q_count_s <= 2'd2)}, 32'd1);
      end
      outReady = 1'b1;
      repeat (10) step();
      pops_random = pops - pops_mark;
      chk("random_progress", {31'd0, (pops_random > 300)}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end. Generates the program counter, drives the instruction memory's synchronous read port, and delivers fetched instructions with their PCs to decode over a valid/ready handshake. It sits between the instruction memory and decode, and absorbs the memory's one-cycle read latency with a 2-entry queue. It also handles backpressure from decode and redirects from execute.

## Interface
Parameters:
- RESET_PC, default 0: first fetch address after reset (byte address, INSN_ADDR_WIDTH bits).
- PC_INC, default 4: byte increment between sequential fetches.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- imemAddr  out  INSN_ADDR_WIDTH  read address. The memory samples it at every posedge.
- imemInsn  in  INSN_WIDTH  read data for the address sampled at the previous posedge.
- outValid  out  1  outInsn/outPc hold a valid instruction.
- outReady  in  1  decode accepts this cycle. A transfer occurs when outValid && outReady.
- outInsn  out  INSN_WIDTH  instruction word.
- outPc  out  INSN_ADDR_WIDTH  byte address of outInsn.
- redirect  in  1  discard all fetched or in-flight instructions and restart at redirectPc.
- redirectPc  in  INSN_ADDR_WIDTH  target address; sampled only when redirect=1.

## Operation
- Registers:
  - fetchPc: next address to issue.
  - reqValid/reqPc: a request was issued at the last edge, so its data is on imemInsn this cycle.
  - queue: 2 entries of {insn, pc} with count 0..2.
  - FSM state.
- FSM states:
  - BOOT (entered during reset): imemAddr=RESET_PC, issue=1; next state RUN.
  - RUN: issue when `count + reqValid - deq <= 1`, where deq = outValid && outReady. If not issuing, next state HOLD.
  - HOLD: imemAddr = last issued address, no issue. Return to RUN when the issue condition holds again.
- Issue: imemAddr=fetchPc. Then fetchPc <= fetchPc + PC_INC (modulo 2^INSN_ADDR_WIDTH, wrap silently), reqValid<=1, reqPc<=fetchPc.
- No issue: reqValid<=0.
- Enqueue: when reqValid=1, {imemInsn, reqPc} is written to the queue at end of cycle, unless bypassed (see Configuration). The issue rule guarantees the queue never overflows.
- Simultaneous enqueue and dequeue: count unchanged, order preserved.
- Output: outValid = (count != 0); outInsn/outPc come from the queue head.
- Redirect has highest priority:
  - imemAddr = redirectPc combinationally in that cycle.
  - Queue count <= 0 and the in-flight data is dropped.
  - reqValid<=1, reqPc<=redirectPc, fetchPc<=redirectPc+PC_INC; state<=RUN.
  - A handshake in the same cycle (outValid && outReady) still counts as a completed transfer.
  - Redirect from HOLD or BOOT behaves identically.
- Reset values: outValid=0, count=0, reqValid=0, fetchPc=RESET_PC, state=BOOT. imemAddr=RESET_PC while reset is asserted.
- Reset asserted mid-operation: all state is cleared immediately. Queued instructions are lost, and no outValid pulse is produced after reset deasserts until a new fetch completes.

## Timing
- Fetch to outValid: 2 cycles without bypass (issue at edge E, data at E+1, outValid after edge E+2).
- Throughput: 1 instruction/cycle while outReady=1.
- Backpressure: with outReady=0 the queue fills to 2 and the FSM enters HOLD within 2 cycles.
- After outReady returns, the next issue happens in the same cycle as the first dequeue. No bubble appears beyond the 2 queued entries.
- Redirect: the first instruction from redirectPc gets outValid 2 cycles after the redirect cycle (1 with bypass).
- imemAddr is combinational from state/redirect. All other outputs are registered or come from the queue head.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count==0 and reqValid=1, outValid=1 with outInsn=imemInsn and outPc=reqPc in the same cycle.
  - If accepted, the entry is not enqueued.
  - Fetch-to-output latency becomes 1; the issue rule is unchanged.
- Not defined: output is taken only from the queue; latency 2.

## Structure
- Shared package (with the existing basic/type packages):
  - FetchEntry struct {InsnPath insn; InsnAddrPath pc}.
  - FETCH_QUEUE_DEPTH=2.
  - Default PC_INC constant tied to INSN_MEM_OFFSET (4 = 1<<INSN_MEM_OFFSET).
- Sub-module fetch_queue: 2-entry FIFO of FetchEntry with enq/deq/flush, count output, and head output. fetch_unit holds the FSM, PC, and request tracking.

## Test plan
- Reset release, memory holds 0x11,0x22,0x33 at 0x0/0x4/0x8, outReady=1: outPc sequence 0x0,0x4,0x8 on consecutive cycles, with first outValid 2 cycles after the BOOT cycle (1 with FETCH_BYPASS_EN).
- outReady=0 for 6 cycles, then 1: count saturates at 2, imemAddr is stuck in HOLD, and no instruction is lost or duplicated (outPc continues 0x0,0x4,…).
- redirect=1 with redirectPc=0x40 while the queue is full and a handshake occurs: the accepted entry is consumed, then the next outValid carries outPc=0x40, then 0x44.
- fetchPc=0xFFFFFFFC (INSN_ADDR_WIDTH=32): next outPc=0x0 with no error.
- rst asserted asynchronously mid-stream with 2 entries queued: outValid drops immediately, and after release fetch restarts at RESET_PC.
- Random outReady toggling for 1000 cycles: outPc strictly sequential with no gaps, and count never exceeds 2.
